// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Byte FIFO plus launch sequencer placed directly in front of a
//            UART transmitter. Host bytes are queued on i_Wr_DV. They are
//            issued one at a time as a one-cycle o_TX_DV pulse. The next byte
//            is not issued until the transmitter reports i_TX_Done.
// Ports    : i_Clock      - single clock, rising edge
//            i_Rst        - synchronous active-high reset
//            i_Wr_DV      - write strobe, one byte per cycle
//            i_Wr_Byte    - byte to enqueue
//            o_Full       - FIFO holds DEPTH bytes
//            o_Empty      - FIFO holds no bytes
//            o_Count      - bytes stored (excludes the byte in flight)
//            o_Overflow   - one-cycle pulse when a write was dropped
//            o_TX_DV      - one-cycle launch pulse to the transmitter
//            o_TX_Byte    - launched byte, held until the next launch
//            i_TX_Active  - transmitter busy
//            i_TX_Done    - transmitter completion pulse
//            o_Busy       - sequencer not idle or bytes still queued
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_Clock,
  input  logic          i_Rst,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [CW-1:0] o_Count,
  output logic          o_Overflow,
  output logic          o_TX_DV,
  output logic [7:0]    o_TX_Byte,
  input  logic          i_TX_Active,
  input  logic          i_TX_Done,
  output logic          o_Busy
);

  localparam int              c_AW       = $clog2(DEPTH);
  localparam logic [c_AW-1:0] c_PTR_ONE  = 1;
  localparam logic [CW-1:0]   c_CNT_ONE  = 1;
  localparam logic [CW-1:0]   c_CNT_FULL = DEPTH[CW-1:0];

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DONE = 2'd1,
    S_GAP       = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic            w_launch;
  logic            w_wr_ok;
  logic            w_full;
  logic            w_empty;
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;
  logic            r_tx_dv;
  logic [7:0]      r_tx_byte;
  logic [7:0]      r_mem [DEPTH];

  // Flags come from the registered count, so a write arriving while full is
  // dropped even if a pop happens on the same edge.
  assign w_full  = (r_count == c_CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = i_Wr_DV && !w_full;

  // State register
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and launch decision. GAP spends one cycle covering the
  // transmitter's cleanup cycle, then may launch directly without passing
  // through IDLE.
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        if (!w_empty && !i_TX_Active) begin
          w_launch     = 1'b1;
          w_next_state = S_WAIT_DONE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (i_TX_Done) begin
          w_next_state = S_GAP;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FIFO storage is intentionally not reset; the pointers define validity.
  always_ff @(posedge i_Clock) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= 8'h00;
    end else begin
      r_overflow <= i_Wr_DV && w_full;
      r_tx_dv    <= w_launch;

      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end

      if (w_launch) begin
        r_tx_byte <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
      end

      // An accepted write and a pop on the same edge leave the count unchanged
      case ({w_wr_ok, w_launch})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_Full     = w_full;
  assign o_Empty    = w_empty;
  assign o_Count    = r_count;
  assign o_Overflow = r_overflow;
  assign o_TX_DV    = r_tx_dv;
  assign o_TX_Byte  = r_tx_byte;
  assign o_Busy     = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Directed self-checking bench for uart_tx_feeder (DEPTH=4). A
//            behavioural transmitter produces an 8N1 frame with 4 clocks per
//            bit. It raises active on launch, and drops active while pulsing
//            done for one cycle at the end of the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int CPB   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_dv;
  logic [7:0]    wr_byte;
  logic          full, empty, overflow, tx_dv, busy;
  logic [CW-1:0] count;
  logic [7:0]    tx_byte;
  logic          tx_active, tx_done;

  logic          m_active, m_done, hold_active, stray_done, serial;
  logic [7:0]    launched [$];
  int            gaps [$];
  int            cyc       = 0;
  int            last_done = -100;
  int            dv_count  = 0;
  int            checks    = 0;
  int            failures  = 0;

  always #5 clk = ~clk;

  assign tx_active = m_active | hold_active;
  assign tx_done   = m_done | stray_done;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .i_Clock    (clk),
    .i_Rst      (rst),
    .i_Wr_DV    (wr_dv),
    .i_Wr_Byte  (wr_byte),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Overflow (overflow),
    .o_TX_DV    (tx_dv),
    .o_TX_Byte  (tx_byte),
    .i_TX_Active(tx_active),
    .i_TX_Done  (tx_done),
    .o_Busy     (busy)
  );

  // Edge counter; remembers the edge at which done was sampled high
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (tx_done) last_done = cyc;
    end
  end

  // Launch monitor: counts every DV cycle and its distance from the last done
  initial begin
    forever begin
      @(negedge clk);
      if (tx_dv === 1'b1) begin
        dv_count++;
        gaps.push_back(cyc - last_done);
      end
    end
  end

  // Behavioural transmitter, sampling DV on the falling edge
  initial begin
    logic [7:0] cur;
    m_active = 1'b0;
    m_done   = 1'b0;
    serial   = 1'b1;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      if (tx_dv === 1'b1) begin
        cur = tx_byte;
        launched.push_back(cur);
        m_active = 1'b1;
        for (int b = 0; b < 10; b++) begin
          serial = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : cur[b-1];
          repeat (CPB) @(negedge clk);
        end
        m_active = 1'b0;
        m_done   = 1'b1;
        serial   = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits until n bytes were launched and everything is idle again
  task automatic wait_drain(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < max_cyc; t++) begin
      @(posedge clk); #1;
      if (launched.size() >= n && !busy && !m_active) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL reset_tx_dv got=%b exp=0", tx_dv); end
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h exp=00", tx_byte); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    logic [9:0] exp_frame;
    bit         found;
    exp_frame = 10'b1_10100101_0;  // stop, A5 MSB..LSB, start
    launched.delete(); dv_count = 0;
    @(negedge clk); wr_dv = 1'b1; wr_byte = 8'hA5;
    @(posedge clk); #1;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count_after_write got=%0d exp=1", count); end
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL single_dv_early got=%b exp=0", tx_dv); end
    @(negedge clk); wr_dv = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_dv !== 1'b1) begin failures++; $display("FAIL single_dv got=%b exp=1", tx_dv); end
    checks++; if (tx_byte !== 8'hA5) begin failures++; $display("FAIL single_byte got=%h exp=a5", tx_byte); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count_after_launch got=%0d exp=0", count); end
    @(negedge clk);
    @(posedge clk); #1;
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL single_dv_width got=%b exp=0", tx_dv); end
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? 2 : 4) @(negedge clk);
      #1;
      checks++;
      if (serial !== exp_frame[b]) begin
        failures++; $display("FAIL single_serial_bit%0d got=%b exp=%b", b, serial, exp_frame[b]);
      end
    end
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(posedge clk);
      if (tx_done) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL single_done_timeout got=none exp=done"); end
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_in_gap got=%b exp=1", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after_gap got=%b exp=0", busy); end
    checks++; if (dv_count != 1) begin failures++; $display("FAIL single_dv_count got=%0d exp=1", dv_count); end
  endtask

  task automatic test_burst();
    int peak;
    bit ok;
    peak = 0;
    launched.delete(); gaps.delete(); dv_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); wr_dv = 1'b1; wr_byte = 8'(i + 1);
      @(posedge clk); #1;
      if (int'(count) > peak) peak = int'(count);
    end
    @(negedge clk); wr_dv = 1'b0;
    checks++; if (peak != 4) begin failures++; $display("FAIL burst_peak_count got=%0d exp=4", peak); end
    wait_drain(5, 600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL burst_drain_timeout got=%0d exp=5", launched.size()); end
    checks++; if (dv_count != 5) begin failures++; $display("FAIL burst_dv_count got=%0d exp=5", dv_count); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= launched.size() || launched[i] !== 8'(i + 1)) begin
        failures++; $display("FAIL burst_order idx=%0d got=%h exp=%h", i, (i < launched.size()) ? launched[i] : 8'hxx, 8'(i + 1));
      end
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (i >= gaps.size() || gaps[i] != 1) begin
        failures++; $display("FAIL burst_done_to_dv idx=%0d got=%0d exp=1", i, (i < gaps.size()) ? gaps[i] : -1);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    launched.delete(); dv_count = 0;
    @(negedge clk); hold_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_dv = 1'b1; wr_byte = 8'(8'hC0 + i);
      @(posedge clk); #1;
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count_full got=%0d exp=4", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", overflow); end
    @(negedge clk); wr_byte = 8'hEE;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL ovf_count_hold got=%0d exp=4", count); end
    @(negedge clk); wr_dv = 1'b0;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pulse_width got=%b exp=0", overflow); end
    checks++; if (dv_count != 0) begin failures++; $display("FAIL ovf_launch_while_active got=%0d exp=0", dv_count); end
    @(negedge clk); hold_active = 1'b0;
    wait_drain(4, 800, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_drain_timeout got=%0d exp=4", launched.size()); end
    checks++; if (launched.size() != 4) begin failures++; $display("FAIL ovf_drain_size got=%0d exp=4", launched.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= launched.size() || launched[i] !== 8'(8'hC0 + i)) begin
        failures++; $display("FAIL ovf_order idx=%0d got=%h exp=%h", i, (i < launched.size()) ? launched[i] : 8'hxx, 8'(8'hC0 + i));
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    launched.delete(); dv_count = 0;
    @(negedge clk); hold_active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); wr_dv = 1'b1; wr_byte = 8'(8'h10 + i);
      @(posedge clk); #1;
    end
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL wrap_count_pre got=%0d exp=2", count); end
    @(negedge clk); hold_active = 1'b0; wr_byte = 8'h12;
    @(posedge clk); #1;
    checks++; if (tx_dv !== 1'b1) begin failures++; $display("FAIL wrap_sim_launch got=%b exp=1", tx_dv); end
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL wrap_sim_count got=%0d exp=2", count); end
    checks++; if (tx_byte !== 8'h10) begin failures++; $display("FAIL wrap_sim_byte got=%h exp=10", tx_byte); end
    wr_dv = 1'b0;
    for (int i = 3; i < 8; i++) begin
      int t;
      t = 0;
      @(negedge clk);
      while (full && t < 200) begin @(negedge clk); t++; end
      wr_dv = 1'b1; wr_byte = 8'(8'h10 + i);
      @(posedge clk); #1;
      wr_dv = 1'b0;
    end
    wait_drain(8, 1200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_drain_timeout got=%0d exp=8", launched.size()); end
    checks++; if (dv_count != 8) begin failures++; $display("FAIL wrap_dv_count got=%0d exp=8", dv_count); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= launched.size() || launched[i] !== 8'(8'h10 + i)) begin
        failures++; $display("FAIL wrap_order idx=%0d got=%h exp=%h", i, (i < launched.size()) ? launched[i] : 8'hxx, 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    launched.delete(); dv_count = 0;
    @(negedge clk); hold_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_dv = 1'b1; wr_byte = 8'(8'h20 + i);
      @(posedge clk); #1;
    end
    @(negedge clk); wr_dv = 1'b0; hold_active = 1'b0;
    @(posedge clk); #1;
    checks++; if (tx_dv !== 1'b1) begin failures++; $display("FAIL rstmid_launch got=%b exp=1", tx_dv); end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL rstmid_queued got=%0d exp=3", count); end
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rstmid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL rstmid_dv got=%b exp=0", tx_dv); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (tx_byte !== 8'h00) begin failures++; $display("FAIL rstmid_tx_byte got=%h exp=00", tx_byte); end
    @(negedge clk); rst = 1'b0;
    t = 0;
    while (m_active && t < 100) begin @(posedge clk); t++; end
    checks++; if (m_active) begin failures++; $display("FAIL rstmid_tx_timeout got=active exp=idle"); end
    repeat (4) @(posedge clk); #1;
    checks++; if (dv_count != 1) begin failures++; $display("FAIL rstmid_late_done_launch got=%0d exp=1", dv_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy_after_done got=%b exp=0", busy); end
  endtask

  task automatic test_stray_done();
    dv_count = 0;
    @(negedge clk); stray_done = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stray_busy got=%b exp=0", busy); end
    checks++; if (tx_dv !== 1'b0) begin failures++; $display("FAIL stray_dv got=%b exp=0", tx_dv); end
    @(negedge clk); stray_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (dv_count != 0) begin failures++; $display("FAIL stray_dv_count got=%0d exp=0", dv_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stray_busy_later got=%b exp=0", busy); end
  endtask

  initial begin
    rst         = 1'b1;
    wr_dv       = 1'b0;
    wr_byte     = 8'h00;
    hold_active = 1'b0;
    stray_done  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_stray_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
